spike_pattern_sequencer: RTL

// - Parametrised training-stimulus sequencer for the ODESA spiking layers. Replays spike patterns

---
 rtl/odesa_seq_pkg.sv | 32 +++
 rtl/seq_lfsr.sv | 29 ++
 rtl/spike_pattern_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/odesa_seq_pkg.sv
// Shared types and width helpers for the ODESA spike pattern sequencer.
// Imported by the sequencer top and its LFSR.
package odesa_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EMIT,
        S_GAP,
        S_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        G_SPIKE,
        G_EVENT,
        G_PAT,
        G_EPOCH
    } gap_sel_e;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'h0001;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) stepping on enable.
// Exposes the low bits of the next state for pattern-base selection.
module seq_lfsr
    import odesa_seq_pkg::*;
#(
    parameter int OW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          en,
    output logic [OW-1:0] nxt_lo
);

    logic [LFSR_W-1:0] q;
    logic [LFSR_W-1:0] q_nxt;

    // Galois form from a non-zero seed never reaches the all-zero state
    assign q_nxt  = {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
    assign nxt_lo = q_nxt[OW-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/spike_pattern_sequencer.sv
// Replays spike patterns from a writable RAM over several epochs with
// programmable spike/event/pattern/epoch gaps and valid/ready output.
module spike_pattern_sequencer
    import odesa_seq_pkg::*;
#(
    parameter int P_CH        = 8,
    parameter int P_LBL       = 4,
    parameter int P_SPIKES    = 8,
    parameter int P_EVENTS    = 2,
    parameter int P_PATTERNS  = 4,
    parameter int P_EPOCHS    = 150,
    parameter int P_INIT_DLY  = 100,
    parameter int P_SPIKE_DLY = 5,
    parameter int P_EVENT_DLY = 60,
    parameter int P_PAT_DLY   = 300,
    parameter int P_EPOCH_DLY = 500,
    parameter int P_SHUFFLE   = 1,
    localparam int DEPTH = P_PATTERNS * P_EVENTS * P_SPIKES,
    localparam int AW    = cw(DEPTH),
    localparam int DW    = P_CH + P_LBL,
    localparam int EW    = $clog2(P_EPOCHS + 1),
    localparam int PW    = cw(P_PATTERNS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [DW-1:0]    i_wr_data,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [P_CH-1:0]  o_spikes,
    output logic [P_LBL-1:0] o_label,
    output logic [EW-1:0]    o_epoch,
    output logic [PW-1:0]    o_pattern,
    output logic             o_busy,
    output logic             o_end_of_epochs
);

    localparam int SW  = cw(P_SPIKES);
    localparam int VW  = cw(P_EVENTS);
    localparam int DLW = cw(max2(max2(P_INIT_DLY, P_SPIKE_DLY),
                         max2(max2(P_EVENT_DLY, P_PAT_DLY),
                              P_EPOCH_DLY)) + 1);

    seq_state_e     state, state_d;
    gap_sel_e       gsel, gsel_d, hs_sel, sel_now;
    logic [DLW-1:0] cnt, cnt_d, hs_len;
    logic [SW-1:0]  spk, spk_d;
    logic [VW-1:0]  evt, evt_d;
    logic [PW-1:0]  kk, kk_d, base, base_d, lfsr_lo;
    logic [EW-1:0]  epoch, epoch_d;
    logic           done_q, done_d, lfsr_en, gap_end;
    logic           spk_last, evt_last, pat_last;
    logic [DW-1:0]  mem [DEPTH];
    logic [DW-1:0]  rd_q;
    logic [AW-1:0]  rd_addr;

    function automatic logic [PW-1:0] wrap(input logic [PW:0] s);
        logic [PW:0] r;
        r = s;
        if (r >= (PW+1)'(P_PATTERNS)) r = r - (PW+1)'(P_PATTERNS);
        return r[PW-1:0];
    endfunction

    function automatic logic [DLW-1:0] gap_len(input gap_sel_e g);
        case (g)
            G_EPOCH: return DLW'(P_EPOCH_DLY);
            G_PAT:   return DLW'(P_PAT_DLY);
            G_EVENT: return DLW'(P_EVENT_DLY);
            default: return DLW'(P_SPIKE_DLY);
        endcase
    endfunction

    seq_lfsr #(.OW(PW)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (lfsr_en),
        .nxt_lo  (lfsr_lo)
    );

    assign spk_last = (spk == SW'(P_SPIKES - 1));
    assign evt_last = (evt == VW'(P_EVENTS - 1));
    assign pat_last = (kk == PW'(P_PATTERNS - 1));

    always_comb begin
        hs_sel = G_SPIKE;
        unique case (1'b1)
            spk_last && evt_last && pat_last:  hs_sel = G_EPOCH;
            spk_last && evt_last && !pat_last: hs_sel = G_PAT;
            spk_last && !evt_last:             hs_sel = G_EVENT;
            !spk_last:                         hs_sel = G_SPIKE;
        endcase
        hs_len = gap_len(hs_sel);
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        gsel_d  = gsel;
        spk_d   = spk;
        evt_d   = evt;
        kk_d    = kk;
        base_d  = base;
        epoch_d = epoch;
        done_d  = done_q;
        lfsr_en = 1'b0;
        gap_end = 1'b0;
        sel_now = gsel;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = S_INIT;
                    cnt_d   = DLW'(P_INIT_DLY);
                    done_d  = 1'b0;
                    epoch_d = EW'(1);
                    spk_d   = '0;
                    evt_d   = '0;
                    kk_d    = '0;
                    base_d  = '0;
                end
            end
            S_INIT: begin
                if (cnt == '0) state_d = S_EMIT;
                else           cnt_d   = cnt - DLW'(1);
            end
            S_EMIT: begin
                if (i_ready) begin
                    spk_d  = spk_last ? '0 : spk + SW'(1);
                    if (spk_last) begin
                        evt_d = evt_last ? '0 : evt + VW'(1);
                        if (evt_last)
                            kk_d = pat_last ? '0 : kk + PW'(1);
                    end
                    gsel_d  = hs_sel;
                    sel_now = hs_sel;
                    if (hs_len == '0) begin
                        gap_end = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = hs_len - DLW'(1);
                    end
                end
            end
            S_GAP: begin
                if (cnt == '0) gap_end = 1'b1;
                else           cnt_d   = cnt - DLW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (gap_end) begin
            state_d = S_EMIT;
            if (sel_now == G_EPOCH) begin
                if (epoch == EW'(P_EPOCHS)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    epoch_d = epoch + EW'(1);
                    lfsr_en = 1'b1;
                    base_d  = (P_SHUFFLE != 0) ? wrap({1'b0, lfsr_lo}) : '0;
                end
            end
        end
        if (i_stop) begin
            state_d = S_IDLE;
            epoch_d = '0;
            spk_d   = '0;
            evt_d   = '0;
            kk_d    = '0;
            base_d  = '0;
            lfsr_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            gsel   <= G_SPIKE;
            spk    <= '0;
            evt    <= '0;
            kk     <= '0;
            base   <= '0;
            epoch  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            gsel   <= gsel_d;
            spk    <= spk_d;
            evt    <= evt_d;
            kk     <= kk_d;
            base   <= base_d;
            epoch  <= epoch_d;
            done_q <= done_d;
        end
    end

    // Read address tracks the next indices so data is ready on EMIT entry
    assign rd_addr = AW'((int'(wrap({1'b0, base_d} + {1'b0, kk_d}))
                         * P_EVENTS + int'(evt_d)) * P_SPIKES
                         + int'(spk_d));

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !o_busy) mem[i_wr_addr] <= i_wr_data;
        rd_q <= mem[rd_addr];
    end

    assign o_valid         = (state == S_EMIT);
    assign o_busy          = (state == S_INIT) || (state == S_EMIT)
                          || (state == S_GAP);
    assign o_spikes        = o_valid ? rd_q[P_CH-1:0] : '0;
    assign o_label         = o_valid ? rd_q[DW-1:P_CH] : '0;
    assign o_epoch         = epoch;
    assign o_pattern       = wrap({1'b0, base} + {1'b0, kk});
    assign o_end_of_epochs = done_q;

endmodule
